life_engine: RTL and testbench

Parametrised, row-serial Conway's Game of Life engine. It holds an ROWS x COLS cell grid in registers and computes one generation by evaluating one row per clock into a shadow buffer, then commits the buffer atomically. It supports seed loading, single-step, free-run, dead-border or toroidal edges, a generation counter, and still-life detection. It sits between the control/IO logic (seed source, run/step buttons) and the display path, which reads `grid`.

---
 rtl/life_engine.sv | 131 +++++++++++++
 tb/tb_life_engine.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/life_engine.sv
// Row-serial Conway's Game of Life engine: one row per clock into a shadow
// buffer, then an atomic commit of the whole generation into the grid.

module life_cell (
   input  logic [2:0] up,
   input  logic [2:0] mid,
   input  logic [2:0] dn,
   output logic       nxt
);
   logic [3:0] cnt;

   assign cnt = 4'(up[0]) + 4'(up[1]) + 4'(up[2]) + 4'(mid[0]) + 4'(mid[2])
              + 4'(dn[0]) + 4'(dn[1]) + 4'(dn[2]);
   assign nxt = (cnt == 4'd3) | ((cnt == 4'd2) & mid[1]);
endmodule

module life_engine #(
   parameter int ROWS           = 8,
   parameter int COLS           = 8,
   parameter int WRAP           = 0,
   parameter int GEN_W          = 16,
   parameter int STOP_ON_STABLE = 1
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 load,
   input  logic [ROWS*COLS-1:0] seed,
   input  logic                 step,
   input  logic                 run,
   output logic [ROWS*COLS-1:0] grid,
   output logic [GEN_W-1:0]     gen_count,
   output logic                 busy,
   output logic                 gen_done,
   output logic                 stable
);
   localparam int RW = $clog2(ROWS);

   typedef enum logic [1:0] {IDLE, EVOLVE, COMMIT} state_t;

   state_t                     state_q, state_d;
   logic [ROWS-1:0][COLS-1:0]  grid_q, shadow_q;
   logic [RW-1:0]              row_q;
   logic [COLS-1:0]            up_r, mid_r, dn_r, nxt_row;
   logic [COLS+1:0]            up_x, mid_x, dn_x;
   logic                       last_row, same;

   assign last_row = (row_q == RW'(ROWS-1));
   assign same     = (shadow_q == grid_q);
   assign grid     = grid_q;
   assign busy     = (state_q != IDLE);

   // Pad each row by one cell on both sides so every column sees a 3-wide window
   function automatic logic [COLS+1:0] extend(input logic [COLS-1:0] r);
      return {(WRAP != 0) ? r[0] : 1'b0, r, (WRAP != 0) ? r[COLS-1] : 1'b0};
   endfunction

   always_comb begin
      mid_r = grid_q[row_q];
      up_r  = '0;
      dn_r  = '0;
      if (row_q == '0) begin
         if (WRAP != 0) up_r = grid_q[ROWS-1];
      end else begin
         up_r = grid_q[row_q - 1'b1];
      end
      if (last_row) begin
         if (WRAP != 0) dn_r = grid_q[0];
      end else begin
         dn_r = grid_q[row_q + 1'b1];
      end
   end

   assign up_x  = extend(up_r);
   assign mid_x = extend(mid_r);
   assign dn_x  = extend(dn_r);

   for (genvar c = 0; c < COLS; c++) begin : g_col
      life_cell u_cell (
         .up  (up_x[c +: 3]),
         .mid (mid_x[c +: 3]),
         .dn  (dn_x[c +: 3]),
         .nxt (nxt_row[c])
      );
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (!load && (step || run)) state_d = EVOLVE;
         EVOLVE:  if (last_row) state_d = COMMIT;
         COMMIT:  state_d = (run && !((STOP_ON_STABLE != 0) && same)) ? EVOLVE : IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= IDLE;
         grid_q    <= '0;
         shadow_q  <= '0;
         row_q     <= '0;
         gen_count <= '0;
         stable    <= 1'b0;
         gen_done  <= 1'b0;
      end else begin
         state_q  <= state_d;
         gen_done <= (state_q == COMMIT);
         case (state_q)
            IDLE: begin
               row_q <= '0;
               if (load) begin
                  grid_q    <= seed;
                  gen_count <= '0;
                  stable    <= 1'b0;
               end
            end
            EVOLVE: begin
               shadow_q[row_q] <= nxt_row;
               row_q           <= last_row ? '0 : row_q + 1'b1;
            end
            COMMIT: begin
               grid_q    <= shadow_q;
               stable    <= same;
               gen_count <= gen_count + 1'b1;
               row_q     <= '0;
            end
            default: row_q <= '0;
         endcase
      end
   end
endmodule

// File: tb/tb_life_engine.sv
// Directed bench for life_engine: three instances (dead border, toroidal,
// 2-bit counter) share stimulus; each task checks the instance it targets.

module tb_life_engine;
   localparam logic [63:0] BLK_H  = 64'h0000_0000_0E00_0000; // bits 25,26,27
   localparam logic [63:0] BLK_V  = 64'h0000_0004_0404_0000; // bits 18,26,34
   localparam logic [63:0] BLOCK  = 64'h0000_0000_0006_0600; // bits 9,10,17,18
   localparam logic [63:0] EDGE   = 64'h0100_0000_0000_0081; // bits 0,7,56
   localparam logic [63:0] EDGE_W = 64'h8100_0000_0000_0081; // + bit 63
   localparam logic [63:0] GLIDER = 64'h0000_0000_0007_0402; // bits 1,10,16,17,18

   logic        clk = 1'b0, reset = 1'b1, load = 1'b0, step = 1'b0, run = 1'b0;
   logic [63:0] seed = '0;
   logic [63:0] grid0, grid1, grid2;
   logic [15:0] gc0, gc1;
   logic [1:0]  gc2;
   logic        busy0, busy1, busy2, gd0, gd1, gd2, st0, st1, st2;
   int          vecs = 0, errs = 0;

   always #5 clk = ~clk;

   life_engine #(.WRAP(0)) dut0 (
      .clk(clk), .reset(reset), .load(load), .seed(seed), .step(step), .run(run),
      .grid(grid0), .gen_count(gc0), .busy(busy0), .gen_done(gd0), .stable(st0));
   life_engine #(.WRAP(1)) dut1 (
      .clk(clk), .reset(reset), .load(load), .seed(seed), .step(step), .run(run),
      .grid(grid1), .gen_count(gc1), .busy(busy1), .gen_done(gd1), .stable(st1));
   life_engine #(.WRAP(0), .GEN_W(2)) dut2 (
      .clk(clk), .reset(reset), .load(load), .seed(seed), .step(step), .run(run),
      .grid(grid2), .gen_count(gc2), .busy(busy2), .gen_done(gd2), .stable(st2));

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_load(input logic [63:0] s);
      seed = s;
      load = 1'b1;
      tick();
      load = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      tick();
      tick();
      vecs++;
      if ({grid0, gc0, busy0, gd0, st0} !== '0)
         begin errs++; $display("FAIL reset0: got grid=%h gc=%0d busy=%b gd=%b st=%b want zeros", grid0, gc0, busy0, gd0, st0); end
      vecs++;
      if ({grid1, gc1, busy1, grid2, gc2, busy2} !== '0)
         begin errs++; $display("FAIL reset12: got grid1=%h gc1=%0d grid2=%h gc2=%0d want zeros", grid1, gc1, grid2, gc2); end
      reset = 1'b0;
      tick();
   endtask

   task automatic test_blinker();
      do_load(BLK_H);
      vecs++;
      if (grid0 !== BLK_H || gc0 !== 16'd0)
         begin errs++; $display("FAIL load: got grid=%h gc=%0d want %h 0", grid0, gc0, BLK_H); end
      step = 1'b1;
      tick();
      step = 1'b0;
      vecs++;
      if (busy0 !== 1'b1) begin errs++; $display("FAIL busy_e0: got %b want 1", busy0); end
      for (int i = 1; i <= 8; i++) begin
         tick();
         vecs++;
         if (grid0 !== BLK_H || busy0 !== 1'b1 || gd0 !== 1'b0)
            begin errs++; $display("FAIL evolve_hold E%0d: got grid=%h busy=%b gd=%b want %h 1 0", i, grid0, busy0, gd0, BLK_H); end
      end
      tick();
      vecs++;
      if (grid0 !== BLK_V || gc0 !== 16'd1 || gd0 !== 1'b1 || busy0 !== 1'b0 || st0 !== 1'b0)
         begin errs++; $display("FAIL blinker1: got grid=%h gc=%0d gd=%b busy=%b st=%b want %h 1 1 0 0", grid0, gc0, gd0, busy0, st0, BLK_V); end
      tick();
      vecs++;
      if (gd0 !== 1'b0) begin errs++; $display("FAIL gen_done_width: got %b want 0", gd0); end
      step = 1'b1;
      tick();
      step = 1'b0;
      repeat (9) tick();
      vecs++;
      if (grid0 !== BLK_H || gc0 !== 16'd2 || st0 !== 1'b0)
         begin errs++; $display("FAIL blinker2: got grid=%h gc=%0d st=%b want %h 2 0", grid0, gc0, st0, BLK_H); end
   endtask

   task automatic test_still_life();
      do_load(BLOCK);
      run = 1'b1;
      tick();
      repeat (9) tick();
      vecs++;
      if (gc0 !== 16'd1 || st0 !== 1'b1 || grid0 !== BLOCK)
         begin errs++; $display("FAIL still_first: got gc=%0d st=%b grid=%h want 1 1 %h", gc0, st0, grid0, BLOCK); end
      for (int i = 0; i < 10; i++) begin
         tick();
         vecs++;
         if (st0 !== 1'b1 || grid0 !== BLOCK)
            begin errs++; $display("FAIL still_hold %0d: got st=%b grid=%h want 1 %h", i, st0, grid0, BLOCK); end
      end
      vecs++;
      if (gc0 !== 16'd2) begin errs++; $display("FAIL still_second: got gc=%0d want 2", gc0); end
      run = 1'b0;
      tick();
      vecs++;
      if (busy0 !== 1'b0 || gc0 !== 16'd2)
         begin errs++; $display("FAIL still_stop: got busy=%b gc=%0d want 0 2", busy0, gc0); end
      repeat (10) tick();
   endtask

   task automatic test_edge();
      do_load(EDGE);
      step = 1'b1;
      tick();
      step = 1'b0;
      repeat (9) tick();
      vecs++;
      if (grid0 !== 64'd0) begin errs++; $display("FAIL edge_dead: got %h want 0", grid0); end
      vecs++;
      if (grid1 !== EDGE_W) begin errs++; $display("FAIL edge_wrap: got %h want %h", grid1, EDGE_W); end
   endtask

   task automatic test_glider();
      int n = 0;
      int last = 0;
      do_load(GLIDER);
      run = 1'b1;
      for (int cyc = 0; cyc < 400 && n < 32; cyc++) begin
         tick();
         if (gd1 === 1'b1) begin
            n++;
            if (n > 1) begin
               vecs++;
               if (cyc - last != 9)
                  begin errs++; $display("FAIL glider_spacing %0d: got %0d want 9", n, cyc - last); end
            end
            last = cyc;
            if (n == 31) run = 1'b0;
         end
      end
      run = 1'b0;
      repeat (12) tick();
      vecs++;
      if (n != 32) begin errs++; $display("FAIL glider_pulses: got %0d want 32", n); end
      vecs++;
      if (grid1 !== GLIDER || gc1 !== 16'd32 || busy1 !== 1'b0)
         begin errs++; $display("FAIL glider_grid: got grid=%h gc=%0d busy=%b want %h 32 0", grid1, gc1, busy1, GLIDER); end
   endtask

   task automatic test_reset_busy();
      do_load(BLK_H);
      step = 1'b1;
      tick();
      step = 1'b0;
      repeat (9) tick();
      step = 1'b1;
      tick();
      step = 1'b0;
      repeat (3) tick();
      vecs++;
      if (grid0 !== BLK_V || gc0 !== 16'd1 || busy0 !== 1'b1)
         begin errs++; $display("FAIL pre_reset: got grid=%h gc=%0d busy=%b want %h 1 1", grid0, gc0, busy0, BLK_V); end
      reset = 1'b1;
      tick();
      vecs++;
      if (grid0 !== 64'd0 || gc0 !== 16'd0 || busy0 !== 1'b0 || gd0 !== 1'b0)
         begin errs++; $display("FAIL mid_reset: got grid=%h gc=%0d busy=%b gd=%b want 0 0 0 0", grid0, gc0, busy0, gd0); end
      reset = 1'b0;
      for (int i = 0; i < 10; i++) begin
         tick();
         vecs++;
         if (gd0 !== 1'b0 || busy0 !== 1'b0 || grid0 !== 64'd0)
            begin errs++; $display("FAIL post_reset %0d: got gd=%b busy=%b grid=%h want 0 0 0", i, gd0, busy0, grid0); end
      end
   endtask

   task automatic test_load_busy();
      do_load(BLK_H);
      step = 1'b1;
      tick();
      step = 1'b0;
      tick();
      seed = BLOCK;
      load = 1'b1;
      tick();
      load = 1'b0;
      vecs++;
      if (grid0 !== BLK_H) begin errs++; $display("FAIL load_busy: got %h want %h", grid0, BLK_H); end
      repeat (7) tick();
      vecs++;
      if (grid0 !== BLK_V || gc0 !== 16'd1)
         begin errs++; $display("FAIL load_busy_commit: got grid=%h gc=%0d want %h 1", grid0, gc0, BLK_V); end
      tick();
      vecs++;
      if (grid0 !== BLK_V) begin errs++; $display("FAIL load_not_queued: got %h want %h", grid0, BLK_V); end
   endtask

   task automatic test_counter_wrap();
      logic [1:0] exp [5] = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
      do_load(BLK_H);
      for (int i = 0; i < 5; i++) begin
         step = 1'b1;
         tick();
         step = 1'b0;
         repeat (9) tick();
         vecs++;
         if (gc2 !== exp[i])
            begin errs++; $display("FAIL gen_wrap %0d: got %0d want %0d", i, gc2, exp[i]); end
      end
   endtask

   task automatic test_back_to_back();
      do_load(BLK_H);
      step = 1'b1;
      tick();
      repeat (9) tick();
      vecs++;
      if (gc0 !== 16'd1 || gd0 !== 1'b1 || busy0 !== 1'b0)
         begin errs++; $display("FAIL b2b_first: got gc=%0d gd=%b busy=%b want 1 1 0", gc0, gd0, busy0); end
      tick();
      vecs++;
      if (busy0 !== 1'b1) begin errs++; $display("FAIL b2b_restart: got busy=%b want 1", busy0); end
      repeat (9) tick();
      vecs++;
      if (gc0 !== 16'd2 || grid0 !== BLK_H)
         begin errs++; $display("FAIL b2b_second: got gc=%0d grid=%h want 2 %h", gc0, grid0, BLK_H); end
      step = 1'b0;
      tick();
      vecs++;
      if (busy0 !== 1'b0) begin errs++; $display("FAIL b2b_stop: got busy=%b want 0", busy0); end
   endtask

   initial begin
      test_reset();
      test_blinker();
      test_still_life();
      test_edge();
      test_glider();
      test_reset_busy();
      test_load_busy();
      test_counter_wrap();
      test_back_to_back();
      $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
      $finish;
   end
endmodule
